// File: rtl/sdram_bist_pkg.sv
// rtl/sdram_bist_pkg.sv - shared types and constants for the SDRAM traffic generator/checker
package sdram_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_DATA,
    S_WR_WAIT,
    S_RD_REQ,
    S_RD_DATA,
    S_RD_WAIT,
    S_DONE
  } state_t;

  localparam logic [1:0] MODE_ALT  = 2'd0;
  localparam logic [1:0] MODE_INC  = 2'd1;
  localparam logic [1:0] MODE_LFSR = 2'd2;

  // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sdram_bist_pattern.sv
// rtl/sdram_bist_pattern.sv - data pattern for word index k; SDRAM_BIST_LFSR_EN builds the LFSR mode
module sdram_bist_pattern
  import sdram_bist_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int K_W    = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic [K_W-1:0]    k,
  output logic [DATA_W-1:0] word
);

`ifdef SDRAM_BIST_LFSR_EN
  logic [15:0] lfsr;

  // All-zero is the LFSR's lock-up state, so a zero seed is replaced by 1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= '0;
    end else if (load) begin
      lfsr <= (16'(seed) == 16'h0) ? 16'h0001 : 16'(seed);
    end else if (step) begin
      lfsr <= lfsr_next(lfsr);
    end
  end
`else
  wire unused_ok = ^{clk, rst_n, load, step};
`endif

  always_comb begin
    word = k[0] ? ~seed : seed;
    if (mode == MODE_INC) word = seed + DATA_W'(k);
`ifdef SDRAM_BIST_LFSR_EN
    if (mode == MODE_LFSR) word = DATA_W'(lfsr);
`endif
  end

endmodule

// File: rtl/sdram_bist.sv
// rtl/sdram_bist.sv - write/read-back traffic generator and checker for sdram_core
// SDRAM_BIST_LFSR_EN enables the LFSR pattern mode.
module sdram_bist
  import sdram_bist_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 24,
  parameter int NUM_W       = 10,
  parameter int BURST_LEN   = 8,
  parameter int NUM_BURSTS  = 4,
  parameter int ADDR_STRIDE = 512,
  parameter int TIMEOUT     = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [NUM_W-1:0]  wr_num,
  output logic [NUM_W-1:0]  rd_num,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_request,
  output logic              rd_request,
  input  logic              wr_allow,
  input  logic              rd_allow,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              busy,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
  output logic              timeout,
  output logic              proto_err
);

  localparam int K_W  = $clog2(NUM_BURSTS * BURST_LEN + 1);
  localparam int B_W  = $clog2(NUM_BURSTS + 1);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t              state, state_nx;
  logic [NUM_W-1:0]    beat;
  logic [B_W-1:0]      burst;
  logic [K_W-1:0]      k;
  logic [WD_W-1:0]     wd;
  logic [ADDR_W-1:0]   base_q, burst_addr;
  logic [1:0]          mode_q;
  logic [DATA_W-1:0]   seed_q, exp_word;
  logic                start_ok, wr_beat, rd_beat, last_beat, last_burst, wd_fire;

  assign start_ok   = start && (state == S_IDLE || state == S_DONE);
  assign wr_beat    = (state == S_WR_DATA) && wr_allow;
  assign rd_beat    = (state == S_RD_DATA) && rd_allow;
  assign last_beat  = (beat == NUM_W'(BURST_LEN - 1));
  assign last_burst = (burst == B_W'(NUM_BURSTS - 1));

  assign running    = (state != S_IDLE) && (state != S_DONE);
  assign done       = (state == S_DONE);
  assign pass       = done && (err_cnt == 16'h0) && !timeout && !proto_err;
  assign wr_request = (state == S_WR_REQ) && !busy;
  assign rd_request = (state == S_RD_REQ) && !busy;
  assign wr_addr    = burst_addr;
  assign rd_addr    = burst_addr;
  assign wr_num     = NUM_W'(BURST_LEN);
  assign rd_num     = NUM_W'(BURST_LEN);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    wd_fire  = 1'b0;
    case (state)
      S_IDLE, S_DONE: if (start)                 state_nx = S_WR_REQ;
      S_WR_REQ:       if (!busy)                 state_nx = S_WR_DATA;
      S_WR_DATA:      if (wr_allow && last_beat) state_nx = S_WR_WAIT;
      S_WR_WAIT:      if (!busy)                 state_nx = last_burst ? S_RD_REQ : S_WR_REQ;
      S_RD_REQ:       if (!busy)                 state_nx = S_RD_DATA;
      S_RD_DATA:      if (rd_allow && last_beat) state_nx = S_RD_WAIT;
      S_RD_WAIT:      if (!busy)                 state_nx = last_burst ? S_DONE : S_RD_REQ;
      default:                                   state_nx = S_IDLE;
    endcase
    // Watchdog only bites when the state would otherwise stay put
    if (running && wd == WD_W'(TIMEOUT - 1) && state_nx == state) begin
      state_nx = S_DONE;
      wd_fire  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat <= '0; burst <= '0; k <= '0; wd <= '0;
      base_q <= '0; burst_addr <= '0; mode_q <= '0; seed_q <= '0;
      err_cnt <= '0; first_err_addr <= '0; first_err_data <= '0;
      timeout <= 1'b0; proto_err <= 1'b0;
    end else begin
      wd <= (state_nx != state) ? '0 : (running ? wd + WD_W'(1) : wd);
      if (start_ok) begin
        mode_q <= mode; seed_q <= seed; base_q <= base_addr; burst_addr <= base_addr;
        beat <= '0; burst <= '0; k <= '0;
        err_cnt <= '0; first_err_addr <= '0; first_err_data <= '0;
        timeout <= 1'b0; proto_err <= 1'b0;
      end else begin
        if (wr_beat || rd_beat) begin
          k    <= k + K_W'(1);
          beat <= last_beat ? '0 : beat + NUM_W'(1);
        end
        if ((state == S_WR_WAIT && state_nx == S_WR_REQ) ||
            (state == S_RD_WAIT && state_nx == S_RD_REQ)) begin
          burst      <= burst + B_W'(1);
          burst_addr <= burst_addr + ADDR_W'(ADDR_STRIDE);
        end
        if (state == S_WR_WAIT && state_nx == S_RD_REQ) begin
          burst      <= '0;
          burst_addr <= base_q;
          k          <= '0;
        end
        if (rd_beat && rd_data != exp_word) begin
          if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
          if (err_cnt == 16'h0) begin
            first_err_addr <= burst_addr + ADDR_W'(beat);
            first_err_data <= rd_data;
          end
        end
        if (wd_fire) timeout <= 1'b1;
        if ((wr_allow && state != S_WR_DATA) || (rd_allow && state != S_RD_DATA))
          proto_err <= 1'b1;
      end
    end
  end

  sdram_bist_pattern #(.DATA_W(DATA_W), .K_W(K_W)) u_wr_pat (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state == S_WR_REQ && burst == '0),
    .step  (wr_beat),
    .mode  (mode_q),
    .seed  (seed_q),
    .k     (k),
    .word  (wr_data)
  );

  sdram_bist_pattern #(.DATA_W(DATA_W), .K_W(K_W)) u_rd_pat (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state == S_RD_REQ && burst == '0),
    .step  (rd_beat),
    .mode  (mode_q),
    .seed  (seed_q),
    .k     (k),
    .word  (exp_word)
  );

endmodule

// File: tb/tb_sdram_bist.sv
// tb/tb_sdram_bist.sv - directed bench for sdram_bist with a behavioural core stub
module tb_sdram_bist;

  logic        clk = 1'b0;
  logic        rst_n, start, wr_allow, rd_allow, busy;
  logic [1:0]  mode;
  logic [15:0] seed, rd_data, wr_data, err_cnt, first_err_data;
  logic [23:0] base_addr, wr_addr, rd_addr, first_err_addr;
  logic [9:0]  wr_num, rd_num;
  logic        wr_request, rd_request, running, done, pass, timeout, proto_err;

  always #5 clk = ~clk;

  sdram_bist dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .seed(seed),
    .base_addr(base_addr), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .wr_num(wr_num), .rd_num(rd_num), .wr_data(wr_data),
    .wr_request(wr_request), .rd_request(rd_request),
    .wr_allow(wr_allow), .rd_allow(rd_allow), .rd_data(rd_data), .busy(busy),
    .running(running), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_addr(first_err_addr), .first_err_data(first_err_data),
    .timeout(timeout), .proto_err(proto_err)
  );

  logic [15:0] mem [logic [23:0]];
  logic [23:0] req_addr [8];
  logic [23:0] bad_addr;
  bit          corrupt;
  int          errors = 0, checks = 0, nwr, nrd, cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rd_mem(input logic [23:0] a);
    return mem.exists(a) ? mem[a] : 16'h0;
  endfunction

  task automatic start_run(input logic [1:0] m, input logic [15:0] s, input logic [23:0] b);
    @(negedge clk); mode = m; seed = s; base_addr = b; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Core stub: answers each request with 8 beats, optionally on alternate cycles
  task automatic service(input int budget, input bit gappy, input bit stray);
    bit wr_act, rd_act, stray_pend;
    int beat;
    logic [23:0] cur;
    wr_act = 0; rd_act = 0; stray_pend = 0; beat = 0; cur = '0; nwr = 0; nrd = 0;
    for (int c = 0; c < budget; c++) begin
      if (done) break;
      wr_allow = 1'b0; rd_allow = 1'b0;
      if (stray_pend) begin
        rd_allow = 1'b1; stray_pend = 0;
      end else if (wr_act && (!gappy || c[0])) begin
        mem[cur + 24'(beat)] = wr_data; wr_allow = 1'b1; beat++;
        if (beat == 8) begin
          wr_act = 0;
          if (stray && nwr == 1) stray_pend = 1;
        end
      end else if (rd_act && (!gappy || c[0])) begin
        rd_data = rd_mem(cur + 24'(beat));
        if (corrupt && (cur + 24'(beat)) == bad_addr) rd_data[0] = ~rd_data[0];
        rd_allow = 1'b1; beat++;
        if (beat == 8) rd_act = 0;
      end
      if (wr_request) begin
        wr_act = 1; beat = 0; cur = wr_addr;
        if (nwr < 8) req_addr[nwr] = wr_addr;
        nwr++;
      end
      if (rd_request) begin
        rd_act = 1; beat = 0; cur = rd_addr; nrd++;
      end
      @(negedge clk);
    end
    wr_allow = 1'b0; rd_allow = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 2'd0; seed = 16'h0; base_addr = 24'h0;
    wr_allow = 1'b0; rd_allow = 1'b0; rd_data = 16'h0; busy = 1'b0; corrupt = 0; bad_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_running", running, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_wr_num", wr_num, 8);
    check("rst_rd_num", rd_num, 8);
    check("rst_wr_data", wr_data, 0);
    check("rst_wr_request", wr_request, 0);
    check("rst_flags", {timeout, proto_err}, 0);
    rst_n = 1'b1;

    // Mode 0, alternating AAAA/5555 from base 0
    start_run(2'd0, 16'hAAAA, 24'h0);
    check("m0_running", running, 1);
    check("m0_req_after_start", wr_request, 1);
    service(2000, 0, 0);
    check("m0_done", done, 1);
    check("m0_pass", pass, 1);
    check("m0_err_cnt", err_cnt, 0);
    check("m0_nwr", nwr, 4);
    check("m0_nrd", nrd, 4);
    check("m0_mem0", rd_mem(24'h0), 16'hAAAA);
    check("m0_mem1", rd_mem(24'h1), 16'h5555);
    check("m0_mem_b1_7", rd_mem(24'd519), 16'h5555);
    check("m0_mem_b3_0", rd_mem(24'd1536), 16'hAAAA);
    check("m0_addr_b2", req_addr[2], 24'd1024);

    // Mode 1 from bank 1 row 1, beats on alternate cycles
    start_run(2'd1, 16'h0100, 24'h400200);
    check("m1_done_cleared", done, 0);
    service(2000, 1, 0);
    check("m1_addr_b2_row3", req_addr[2], 24'h400600);
    check("m1_mem_first", rd_mem(24'h400200), 16'h0100);
    check("m1_mem_k21", rd_mem(24'h400605), 16'h0115);
    check("m1_mem_last", rd_mem(24'h400807), 16'h011F);
    check("m1_pass", pass, 1);

    // Mode 2 with seed 0
    start_run(2'd2, 16'h0000, 24'h001000);
    service(2000, 0, 0);
`ifdef SDRAM_BIST_LFSR_EN
    check("m2_w0", rd_mem(24'h001000), 16'h0001);
    check("m2_w1", rd_mem(24'h001001), 16'h0002);
    check("m2_w10", rd_mem(24'h001202), 16'h0400);
`else
    check("m2_w0", rd_mem(24'h001000), 16'h0000);
    check("m2_w1", rd_mem(24'h001001), 16'hFFFF);
    check("m2_w10", rd_mem(24'h001202), 16'h0000);
`endif
    check("m2_pass", pass, 1);

    // Bit 0 flipped on read at burst 1 beat 3
    corrupt = 1; bad_addr = 24'h400403;
    start_run(2'd1, 16'h0100, 24'h400200);
    service(2000, 0, 0);
    corrupt = 0;
    check("cor_done", done, 1);
    check("cor_err_cnt", err_cnt, 1);
    check("cor_first_addr", first_err_addr, 24'h400403);
    check("cor_first_data", first_err_data, 16'h010A);
    check("cor_pass", pass, 0);

    // Stray rd_allow in WR_WAIT after burst 0
    start_run(2'd0, 16'h3C3C, 24'h0);
    service(2000, 0, 1);
    check("stray_done", done, 1);
    check("stray_proto_err", proto_err, 1);
    check("stray_err_cnt", err_cnt, 0);
    check("stray_pass", pass, 0);

    // Core stuck busy: watchdog ends the run
    busy = 1'b1;
    start_run(2'd0, 16'h1111, 24'h0);
    cyc = 0; nwr = 0;
    for (int c = 0; c < 10000; c++) begin
      if (done) break;
      if (wr_request) nwr++;
      cyc++;
      @(negedge clk);
    end
    busy = 1'b0;
    check("to_cycles", cyc, 4096);
    check("to_timeout", timeout, 1);
    check("to_done", done, 1);
    check("to_pass", pass, 0);
    check("to_no_request", nwr, 0);

    // Reset in the middle of a write burst, then rerun
    start_run(2'd0, 16'h1234, 24'h0);
    service(5, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_running", running, 0);
    check("mid_rst_request", wr_request, 0);
    check("mid_rst_flags", {done, timeout, proto_err}, 0);
    check("mid_rst_wr_data", wr_data, 0);
    rst_n = 1'b1;
    start_run(2'd0, 16'h1234, 24'h0);
    service(2000, 0, 0);
    check("rerun_pass", pass, 1);
    check("rerun_mem1", rd_mem(24'h1), 16'hEDCB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
